// File: rtl/eth_mac_tx_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// eth_mac_pkg : shared state encoding, arbitration modes and width helper
//               for the MAC TX frame arbiter.                  Rev 1.0
// ==========================================================================
package eth_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam logic ARB_RR   = 1'b0;
  localparam logic ARB_PRIO = 1'b1;

  // Width of an index/counter, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_mac_tx_arbiter_if.sv
`default_nettype none
// ==========================================================================
// eth_mac_tx_arbiter_if : bundled source/sink streams and status of the
//                         MAC TX frame arbiter.                Rev 1.0
// ==========================================================================
interface eth_mac_tx_arbiter_if
  import eth_mac_pkg::*;
#(
  parameter int C_NUM_CH     = 4,
  parameter int C_DATA_WIDTH = 8
);
  localparam int GW = clog2_min1(C_NUM_CH);

  logic [C_NUM_CH-1:0]              ch_enable;
  logic [C_NUM_CH*C_DATA_WIDTH-1:0] s_axis_tdata;
  logic [C_NUM_CH-1:0]              s_axis_tvalid;
  logic [C_NUM_CH-1:0]              s_axis_tlast;
  logic [C_NUM_CH-1:0]              s_axis_tready;
  logic [C_DATA_WIDTH-1:0]          m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tuser;
  logic                             m_axis_tready;
  logic [GW-1:0]                    grant_ch;
  logic                             busy;
  logic                             abort_pulse;

  modport slave (
    input  ch_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           grant_ch, busy, abort_pulse
  );

  modport master (
    output ch_enable, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           grant_ch, busy, abort_pulse
  );

endinterface
`default_nettype wire

// File: rtl/eth_mac_tx_arbiter_rr.sv
`default_nettype none
// ==========================================================================
// eth_rr_arbiter : combinational round-robin / fixed-priority picker;
//                  the previous grant is held by the parent.   Rev 1.0
// ==========================================================================
module eth_rr_arbiter
  import eth_mac_pkg::*;
#(
  parameter int C_NUM_CH = 4,
  parameter int GW       = clog2_min1(C_NUM_CH)
) (
  input  logic [C_NUM_CH-1:0] req,
  input  logic [GW-1:0]       last_grant,
  input  logic                mode,
  output logic [C_NUM_CH-1:0] grant_onehot,
  output logic [GW-1:0]       grant_idx
);

  int            idx;
  logic [GW-1:0] pos;

  // Candidates are scanned from lowest to highest precedence so the last
  // match written is the winner.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    idx          = 0;
    pos          = '0;
    for (int k = C_NUM_CH; k >= 1; k--) begin
      if (mode == ARB_PRIO) begin
        idx = k - 1;
      end else begin
        idx = int'(last_grant) + k;
        if (idx >= C_NUM_CH) begin
          idx = idx - C_NUM_CH;
        end
      end
      pos = GW'(idx);
      if (req[pos]) begin
        grant_onehot      = '0;
        grant_onehot[pos] = 1'b1;
        grant_idx         = pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_mac_tx_arbiter.sv
`default_nettype none
// ==========================================================================
// eth_mac_tx_arbiter : merges N AXI-Stream sources into the MAC TX stream
//                      frame by frame, with idle-timeout abort. Rev 1.0
// ==========================================================================
module eth_mac_tx_arbiter
  import eth_mac_pkg::*;
#(
  parameter int C_NUM_CH     = 4,
  parameter int C_DATA_WIDTH = 8,
  parameter int C_ARB_MODE   = 0,
  parameter int C_TIMEOUT    = 1024
) (
  input  logic                tx_mac_aclk,
  input  logic                tx_mac_resetn,
  eth_mac_tx_arbiter_if.slave axis
);

  localparam int            GW          = clog2_min1(C_NUM_CH);
  localparam int            CW          = clog2_min1(C_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(C_TIMEOUT);
  localparam bit            TIMEOUT_EN  = (C_TIMEOUT != 0);
  localparam logic          MODE        = (C_ARB_MODE != 0) ? ARB_PRIO : ARB_RR;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_XFER  = ST_XFER;
  localparam logic [1:0] S_ABORT = ST_ABORT;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [1:0]              state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [CW-1:0]           idle_cnt;
  logic [CW-1:0]           idle_cnt_inc;
  logic                    timeout_hit;

  logic [C_NUM_CH-1:0]     req;
  logic [C_NUM_CH-1:0]     arb_onehot;
  logic [GW-1:0]           arb_idx;

  logic [C_DATA_WIDTH-1:0] ch_data [C_NUM_CH];
  logic [C_DATA_WIDTH-1:0] g_data;
  logic                    g_valid;
  logic                    g_last;

  logic [C_NUM_CH-1:0]     out_ready;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_user;
  logic                    out_abort;

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = axis.s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  assign req     = axis.s_axis_tvalid & axis.ch_enable;
  assign g_data  = ch_data[grant];
  assign g_valid = axis.s_axis_tvalid[grant];
  assign g_last  = axis.s_axis_tlast[grant];

  eth_rr_arbiter #(
    .C_NUM_CH (C_NUM_CH),
    .GW       (GW)
  ) u_arb (
    .req          (req),
    .last_grant   (last_grant),
    .mode         (MODE),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  // Saturating so a long stall can never wrap back below the threshold.
  assign idle_cnt_inc = (idle_cnt == TIMEOUT_VAL) ? idle_cnt : idle_cnt + 1'b1;
  assign timeout_hit  = TIMEOUT_EN && !g_valid && (idle_cnt_inc == TIMEOUT_VAL);

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= GW'(C_NUM_CH - 1);
      idle_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|arb_onehot) begin
            grant    <= arb_idx;
            idle_cnt <= '0;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          idle_cnt <= g_valid ? '0 : idle_cnt_inc;
          if (g_valid && g_last && axis.m_axis_tready) begin
            last_grant <= grant;
            state      <= S_IDLE;
          end else if (timeout_hit) begin
            state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (axis.m_axis_tready) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (g_valid && g_last) begin
            last_grant <= grant;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_ready = '0;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_user  = 1'b0;
    out_abort = 1'b0;
    case (state)
      S_XFER: begin
        out_data         = g_data;
        out_valid        = g_valid;
        out_last         = g_last;
        out_ready[grant] = axis.m_axis_tready;
      end
      S_ABORT: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_user  = 1'b1;
        out_abort = axis.m_axis_tready;
      end
      S_DRAIN: begin
        out_ready[grant] = 1'b1;
      end
      default: ;
    endcase
  end

  assign axis.s_axis_tready = out_ready;
  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tlast  = out_last;
  assign axis.m_axis_tuser  = out_user;
  assign axis.abort_pulse   = out_abort;
  assign axis.grant_ch      = grant;
  assign axis.busy          = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_mac_tx_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_eth_mac_tx_arbiter : directed bench for the MAC TX frame arbiter,
//                         round-robin and fixed-priority instances. Rev 1.0
// ==========================================================================
module tb_eth_mac_tx_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  eth_mac_tx_arbiter_if #(.C_NUM_CH(4), .C_DATA_WIDTH(8)) bus_rr ();
  eth_mac_tx_arbiter_if #(.C_NUM_CH(4), .C_DATA_WIDTH(8)) bus_fp ();

  eth_mac_tx_arbiter #(
    .C_NUM_CH(4), .C_DATA_WIDTH(8), .C_ARB_MODE(0), .C_TIMEOUT(4)
  ) u_rr (
    .tx_mac_aclk   (clk),
    .tx_mac_resetn (resetn),
    .axis          (bus_rr)
  );

  eth_mac_tx_arbiter #(
    .C_NUM_CH(4), .C_DATA_WIDTH(8), .C_ARB_MODE(1), .C_TIMEOUT(8)
  ) u_fp (
    .tx_mac_aclk   (clk),
    .tx_mac_resetn (resetn),
    .axis          (bus_fp)
  );

  int n_chk = 0;
  int n_err = 0;

  // Source model: channel i sends frames of len[i] beats, byte = i*64 + beat.
  int         sel;
  logic [3:0] en, act, hold;
  logic       mready;
  int         len  [4];
  int         sent [4];
  int         done [4];
  int         aborts;

  logic [3:0] o_tready;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_user, o_busy, o_abort;
  logic [1:0] o_grant;

  int rr_order [5] = '{0, 1, 2, 3, 0};
  int en_order [4] = '{1, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    logic [3:0]  tv, tl;
    logic [31:0] td;
    for (int i = 0; i < 4; i++) begin
      tv[i]         = act[i] & ~hold[i];
      tl[i]         = (sent[i] == len[i] - 1);
      td[i*8 +: 8]  = 8'(i * 64 + sent[i]);
    end
    if (sel == 0) begin
      bus_rr.ch_enable = en;  bus_rr.s_axis_tvalid = tv;  bus_rr.s_axis_tlast = tl;
      bus_rr.s_axis_tdata = td;  bus_rr.m_axis_tready = mready;
      bus_fp.ch_enable = '0;  bus_fp.s_axis_tvalid = '0;  bus_fp.s_axis_tlast = '0;
      bus_fp.s_axis_tdata = '0;  bus_fp.m_axis_tready = 1'b0;
    end else begin
      bus_fp.ch_enable = en;  bus_fp.s_axis_tvalid = tv;  bus_fp.s_axis_tlast = tl;
      bus_fp.s_axis_tdata = td;  bus_fp.m_axis_tready = mready;
      bus_rr.ch_enable = '0;  bus_rr.s_axis_tvalid = '0;  bus_rr.s_axis_tlast = '0;
      bus_rr.s_axis_tdata = '0;  bus_rr.m_axis_tready = 1'b0;
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_tready = bus_rr.s_axis_tready;  o_data = bus_rr.m_axis_tdata;
      o_valid  = bus_rr.m_axis_tvalid;  o_last = bus_rr.m_axis_tlast;
      o_user   = bus_rr.m_axis_tuser;   o_busy = bus_rr.busy;
      o_abort  = bus_rr.abort_pulse;    o_grant = bus_rr.grant_ch;
    end else begin
      o_tready = bus_fp.s_axis_tready;  o_data = bus_fp.m_axis_tdata;
      o_valid  = bus_fp.m_axis_tvalid;  o_last = bus_fp.m_axis_tlast;
      o_user   = bus_fp.m_axis_tuser;   o_busy = bus_fp.busy;
      o_abort  = bus_fp.abort_pulse;    o_grant = bus_fp.grant_ch;
    end
  endtask

  // One clock cycle, entered and left on a falling edge; outputs are
  // sampled mid-cycle and source handshakes are advanced accordingly.
  task automatic step();
    apply();
    #1;
    sample();
    for (int i = 0; i < 4; i++) begin
      if (act[i] && !hold[i] && o_tready[i]) begin
        if (sent[i] == len[i] - 1) begin
          sent[i] = 0;
          done[i]++;
        end else begin
          sent[i]++;
        end
      end
    end
    if (o_abort) aborts++;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tvalid"}, 32'(o_valid), 32'd0);
    check({tag, "_tlast"},  32'(o_last),  32'd0);
    check({tag, "_tuser"},  32'(o_user),  32'd0);
    check({tag, "_tready"}, 32'(o_tready), 32'd0);
    check({tag, "_grant"},  32'(o_grant), 32'd0);
    check({tag, "_busy"},   32'(o_busy),  32'd0);
    check({tag, "_abort"},  32'(o_abort), 32'd0);
  endtask

  // Cycle c of a repeating "1 arbitration/dead cycle + flen beats" pattern.
  task automatic frame_cycle(input string tag, input int c, input int ch, input int flen);
    int pos;
    pos = c % (flen + 1);
    if (pos == 0) begin
      check({tag, "_gap_valid"}, 32'(o_valid), 32'd0);
    end else begin
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_grant"}, 32'(o_grant), 32'(ch));
      check({tag, "_data"},  32'(o_data),  32'(ch * 64 + pos - 1));
      check({tag, "_last"},  32'(o_last),  32'(pos == flen));
    end
  endtask

  initial begin
    int k;
    int done0;
    resetn = 1'b0;
    sel = 0; en = '0; act = '0; hold = '0; mready = 1'b1; aborts = 0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 3; sent[i] = 0; done[i] = 0;
    end
    apply();
    #1;
    sample();
    check_reset("rst_rr");
    sel = 1;
    sample();
    check_reset("rst_fp");
    sel = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Round-robin, all channels streaming 3-beat frames.
    en = 4'hF; act = 4'hF;
    for (int c = 0; c < 20; c++) begin
      step();
      frame_cycle("rr", c, rr_order[c / 4], 3);
    end
    act = '0;
    step();
    check("rr_idle_busy", 32'(o_busy), 32'd0);

    // Channel 2 masked; channel 0 masked in the middle of its own frame.
    en = 4'b1011; act = 4'hF;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) en = 4'b1010;
      step();
      frame_cycle("en", c, en_order[c / 4], 3);
    end
    act = '0; en = 4'hF;
    step();

    // 64-beat frame from channel 2 with tready toggling every cycle.
    act = 4'b0100; len[2] = 64; aborts = 0; k = 0;
    for (int c = 0; c < 400 && k < 64; c++) begin
      mready = (c % 2 == 1);
      step();
      if (o_valid && mready) begin
        check("bp_data", 32'(o_data), 32'(128 + k));
        check("bp_user", 32'(o_user), 32'd0);
        if (k == 63) check("bp_last", 32'(o_last), 32'd1);
        k++;
      end
    end
    check("bp_beats", 32'(k), 32'd64);
    check("bp_aborts", 32'(aborts), 32'd0);
    act = '0; mready = 1'b1;
    step();

    // Fixed priority: channel 1 keeps winning over channel 3.
    sel = 1; len[1] = 2; len[3] = 2; act = 4'b1010;
    for (int c = 0; c < 9; c++) begin
      step();
      frame_cycle("prio", c, 1, 2);
    end
    act = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step();
      frame_cycle("prio3", c, 3, 2);
    end
    act = '0;
    step();

    // Idle timeout of 8 cycles on channel 0 after two beats.
    len[0] = 6; act = 4'b0001; aborts = 0; done0 = done[0];
    step();
    check("to_arb_valid", 32'(o_valid), 32'd0);
    step();
    check("to_b0_data", 32'(o_data), 32'd0);
    step();
    check("to_b1_data", 32'(o_data), 32'd1);
    check("to_b1_valid", 32'(o_valid), 32'd1);
    hold = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      check("to_gap_valid", 32'(o_valid), 32'd0);
      check("to_gap_busy", 32'(o_busy), 32'd1);
    end
    step();
    check("to_ab_valid", 32'(o_valid), 32'd1);
    check("to_ab_last",  32'(o_last),  32'd1);
    check("to_ab_user",  32'(o_user),  32'd1);
    check("to_ab_data",  32'(o_data),  32'd0);
    check("to_ab_pulse", 32'(o_abort), 32'd1);
    check("to_ab_tready", 32'(o_tready), 32'd0);
    hold = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("to_drain_valid", 32'(o_valid), 32'd0);
      check("to_drain_tready", 32'(o_tready), 32'b0001);
    end
    act = '0;
    step();
    check("to_end_busy", 32'(o_busy), 32'd0);
    check("to_frames", 32'(done[0] - done0), 32'd1);
    check("to_pulses", 32'(aborts), 32'd1);

    // Reset asserted mid-frame, then channel 0 wins first.
    sel = 0; len[3] = 5; act = 4'b1000;
    step();
    step();
    step();
    check("mid_valid_pre", 32'(o_valid), 32'd1);
    resetn = 1'b0;
    #2;
    sample();
    check_reset("mid_rst");
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0; len[i] = 3;
    end
    @(negedge clk);
    resetn = 1'b1;
    act = 4'hF;
    step();
    check("post_arb_valid", 32'(o_valid), 32'd0);
    step();
    check("post_grant", 32'(o_grant), 32'd0);
    check("post_valid", 32'(o_valid), 32'd1);
    check("post_data",  32'(o_data),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
